// File: rtl/pd_tx_framer.sv
// USB-PD transmit framer: preamble, SOP ordered set, 4b5b payload, CRC32 and EOP,
// one bit per encoder bit_rdy pulse, plus encoder enable/flush sequencing.
module pd_tx_framer #(
  parameter int PREAMBLE_BITS = 64
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] sop_sel,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  input  logic       bit_rdy,
  output logic       tx_en,
  output logic       tx_bit,
  output logic       tx_flush,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int          PW       = (PREAMBLE_BITS > 2) ? $clog2(PREAMBLE_BITS) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BITS - 1);

  localparam logic [4:0] K_SYNC1 = 5'b11000;
  localparam logic [4:0] K_SYNC2 = 5'b10001;
  localparam logic [4:0] K_SYNC3 = 5'b00110;
  localparam logic [4:0] K_EOP   = 5'b01101;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SOP, S_DATA, S_CRC, S_EOP, S_FLUSH
  } state_t;

  function automatic logic [4:0] enc4b5b(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;  4'h1: return 5'b01001;
      4'h2: return 5'b10100;  4'h3: return 5'b10101;
      4'h4: return 5'b01010;  4'h5: return 5'b01011;
      4'h6: return 5'b01110;  4'h7: return 5'b01111;
      4'h8: return 5'b10010;  4'h9: return 5'b10011;
      4'hA: return 5'b10110;  4'hB: return 5'b10111;
      4'hC: return 5'b11010;  4'hD: return 5'b11011;
      4'hE: return 5'b11100;  default: return 5'b11101;
    endcase
  endfunction

  // sel 3 has already been folded onto 0 when captured.
  function automatic logic [4:0] sop_sym(input logic [1:0] sel, input logic [1:0] idx);
    case (sel)
      2'd1:    return (idx < 2'd2) ? K_SYNC1 : K_SYNC3;
      2'd2:    return idx[0] ? K_SYNC3 : K_SYNC1;
      default: return (idx == 2'd3) ? K_SYNC2 : K_SYNC1;
    endcase
  endfunction

  function automatic logic [31:0] crc32_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  state_t        state;
  logic [PW-1:0] pre_cnt;
  logic [2:0]    bidx;
  logic [2:0]    sidx;
  logic [4:0]    cur_sym;
  logic [1:0]    sop_reg;
  logic [7:0]    byte_reg;
  logic          last_reg;
  logic          hi_nib;
  logic [31:0]   crc;

  logic [31:0]   crc_tx;
  logic [2:0]    nib_idx;
  logic          fetch;
  logic [4:0]    new_sym;

  assign crc_tx  = ~crc;
  assign nib_idx = sidx + 3'd1;
  assign fetch   = bit_rdy && (bidx == 3'd4) &&
                   (((state == S_SOP) && (sidx == 3'd3)) ||
                    ((state == S_DATA) && hi_nib && !last_reg));
  // NOTE: s_ready is combinational so the byte is taken in the very bit_rdy cycle
  // that ends the preceding symbol; a registered ready would lag by one cycle.
  assign s_ready = s_valid & fetch;

  // Symbol to load at the next symbol boundary of the current state.
  always_comb begin
    // NOTE: default first so every path assigns new_sym and no latch is inferred.
    new_sym = K_EOP;
    case (state)
      S_PRE:  new_sym = sop_sym(sop_reg, 2'd0);
      S_SOP:
        if (sidx == 3'd3) new_sym = s_valid ? enc4b5b(s_data[3:0]) : K_EOP;
        else              new_sym = sop_sym(sop_reg, nib_idx[1:0]);
      S_DATA:
        if (!hi_nib)       new_sym = enc4b5b(byte_reg[7:4]);
        else if (last_reg) new_sym = enc4b5b(crc_tx[3:0]);
        else               new_sym = s_valid ? enc4b5b(s_data[3:0]) : K_EOP;
      S_CRC:
        if (sidx != 3'd7) new_sym = enc4b5b(crc_tx[{nib_idx, 2'b00} +: 4]);
      default: new_sym = K_EOP;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every branch sees
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (rst) begin
      state    <= S_IDLE;
      pre_cnt  <= '0;
      bidx     <= '0;
      sidx     <= '0;
      cur_sym  <= '0;
      sop_reg  <= '0;
      byte_reg <= '0;
      last_reg <= 1'b0;
      hi_nib   <= 1'b0;
      crc      <= '1;
      tx_en    <= 1'b0;
      tx_bit   <= 1'b0;
      tx_flush <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE:
          if (start) begin
            state    <= S_PRE;
            busy     <= 1'b1;
            tx_en    <= 1'b1;
            tx_bit   <= 1'b0;
            pre_cnt  <= '0;
            last_reg <= 1'b0;
            crc      <= '1;
            sop_reg  <= (sop_sel == 2'd3) ? 2'd0 : sop_sel;
          end
        S_PRE:
          if (bit_rdy) begin
            if (pre_cnt == PRE_LAST) begin
              state   <= S_SOP;
              sidx    <= '0;
              bidx    <= '0;
              cur_sym <= new_sym;
              tx_bit  <= new_sym[0];
            end else begin
              pre_cnt <= pre_cnt + PW'(1);
              tx_bit  <= ~tx_bit;
            end
          end
        S_SOP, S_DATA, S_CRC, S_EOP:
          if (bit_rdy) begin
            if (bidx != 3'd4) begin
              bidx   <= bidx + 3'd1;
              tx_bit <= cur_sym[bidx + 3'd1];
            end else begin
              bidx    <= '0;
              sidx    <= sidx + 3'd1;
              cur_sym <= new_sym;
              tx_bit  <= new_sym[0];
              if (fetch) begin
                if (s_valid) begin
                  byte_reg <= s_data;
                  last_reg <= s_last;
                  hi_nib   <= 1'b0;
                  crc      <= crc32_byte(crc, s_data);
                  state    <= S_DATA;
                end else begin
                  err   <= 1'b1;
                  state <= S_EOP;
                end
              end else begin
                case (state)
                  S_DATA:
                    if (!hi_nib) hi_nib <= 1'b1;
                    else begin
                      state <= S_CRC;
                      sidx  <= '0;
                    end
                  S_CRC: if (sidx == 3'd7) state <= S_EOP;
                  S_EOP: begin
                    state    <= S_FLUSH;
                    tx_flush <= 1'b1;
                    tx_bit   <= 1'b0;
                  end
                  default: ;
                endcase
              end
            end
          end
        S_FLUSH:
          if (bit_rdy) begin
            state    <= S_IDLE;
            tx_en    <= 1'b0;
            tx_flush <= 1'b0;
            tx_bit   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pd_tx_framer.sv
// Directed bench for pd_tx_framer: captures the bit stream per bit_rdy and compares it
// with a stream built from hand 4b5b tables and a bitwise CRC-32 model.
module tb_pd_tx_framer;

  localparam int PB = 64;

  logic       clock = 1'b0;
  logic       rst, start, s_valid, s_last, bit_rdy;
  logic [1:0] sop_sel;
  logic [7:0] s_data;
  logic       s_ready, tx_en, tx_bit, tx_flush, busy, done, err;

  pd_tx_framer #(.PREAMBLE_BITS(PB)) dut (
    .clock(clock), .rst(rst), .start(start), .sop_sel(sop_sel),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .bit_rdy(bit_rdy), .tx_en(tx_en), .tx_bit(tx_bit), .tx_flush(tx_flush),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  int   rdy_period = 4;
  int   rdy_cnt    = 0;
  logic [7:0] pay[$];
  bit   pay_last;
  int   src_idx = 0;
  bit   acc;
  logic cap_bit[$];
  logic cap_fl[$];
  logic exp_q[$];
  int   sr_cnt = 0, done_cnt = 0, err_cnt = 0;

  localparam logic [4:0] S1 = 5'b11000, S2 = 5'b10001, S3 = 5'b00110, EOPK = 5'b01101;

  function automatic logic [4:0] enc5(input logic [3:0] n);
    logic [4:0] t [16] = '{5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011,
                           5'b01110, 5'b01111, 5'b10010, 5'b10011, 5'b10110, 5'b10111,
                           5'b11010, 5'b11011, 5'b11100, 5'b11101};
    return t[n];
  endfunction

  function automatic logic [3:0] dec5(input logic [4:0] s);
    for (int i = 0; i < 16; i++)
      if (enc5(4'(i)) == s) return 4'(i);
    return 4'hx;
  endfunction

  task automatic src_update();
    s_valid = (src_idx < pay.size());
    s_data  = s_valid ? pay[src_idx] : 8'h00;
    s_last  = s_valid && pay_last && (src_idx == pay.size() - 1);
  endtask

  task automatic load_payload(input logic [7:0] b[$], input bit last);
    pay      = b;
    pay_last = last;
    src_idx  = 0;
    src_update();
  endtask

  task automatic push_sym(input logic [4:0] s);
    for (int b = 0; b < 5; b++) exp_q.push_back(s[b]);
  endtask

  task automatic build_expected(input logic [4:0] k0, k1, k2, k3);
    logic [31:0] c;
    exp_q.delete();
    for (int i = 0; i < PB; i++) exp_q.push_back(1'(i % 2));
    push_sym(k0); push_sym(k1); push_sym(k2); push_sym(k3);
    c = 32'hFFFFFFFF;
    foreach (pay[i]) begin
      push_sym(enc5(pay[i][3:0]));
      push_sym(enc5(pay[i][7:4]));
      for (int b = 0; b < 8; b++)
        c = (c[0] ^ pay[i][b]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    if (pay_last) begin
      c = ~c;
      for (int n = 0; n < 8; n++) push_sym(enc5(c[4*n +: 4]));
    end
    push_sym(EOPK);
  endtask

  // bit_rdy pulse generator, free-running (also while the DUT is idle)
  initial begin
    bit_rdy = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (rdy_cnt >= rdy_period - 1) begin rdy_cnt = 0; bit_rdy = 1'b1; end
      else begin rdy_cnt++; bit_rdy = 1'b0; end
    end
  end

  // byte source: advance after a handshake edge
  initial begin
    forever begin
      @(negedge clock);
      acc = s_valid && s_ready;
      @(posedge clock); #1;
      if (acc) begin src_idx++; src_update(); end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clock);
      if (bit_rdy && tx_en) begin cap_bit.push_back(tx_bit); cap_fl.push_back(tx_flush); end
      if (s_ready) sr_cnt++;
      if (done)    done_cnt++;
      if (err)     err_cnt++;
    end
  end

  // Call at a negedge; returns at the negedge where done is seen.
  task automatic run_frame(input logic [1:0] sel, input bit poke, input string name);
    bit seen;
    cap_bit.delete(); cap_fl.delete();
    sr_cnt = 0; done_cnt = 0; err_cnt = 0;
    sop_sel = sel;
    start   = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    total++;
    if ({busy, tx_en, tx_bit, done} !== 4'b1100) begin
      bad++;
      $display("FAIL %s start_latency: {busy,tx_en,tx_bit,done}=%b want 1100", name, {busy, tx_en, tx_bit, done});
    end
    seen = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      @(negedge clock);
      if (poke && i == 300) begin start = 1'b1; sop_sel = 2'd2; end
      if (poke && i == 301) start = 1'b0;
      if (done) begin seen = 1'b1; break; end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s done_timeout: no done within 40000 cycles", name);
    end
    total++;
    if ({busy, tx_en, tx_flush} !== 3'b000) begin
      bad++;
      $display("FAIL %s done_release: {busy,tx_en,tx_flush}=%b want 000", name, {busy, tx_en, tx_flush});
    end
  endtask

  task automatic verify_stream(input string name, input int exp_ready, input int exp_err);
    int mism, flpos, flones;
    mism = 0; flones = 0; flpos = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= cap_bit.size() || cap_bit[i] !== exp_q[i]) mism++;
    foreach (cap_fl[i]) if (cap_fl[i] === 1'b1) begin flones++; flpos = i; end
    total++;
    if (cap_bit.size() !== exp_q.size() + 1) begin
      bad++;
      $display("FAIL %s bit_periods: got %0d want %0d", name, cap_bit.size(), exp_q.size() + 1);
    end
    total++;
    if (mism !== 0) begin
      bad++;
      $display("FAIL %s bitstream: %0d wrong bits", name, mism);
    end
    total++;
    if (flones !== 1 || flpos !== exp_q.size()) begin
      bad++;
      $display("FAIL %s flush: ones=%0d at %0d want 1 at %0d", name, flones, flpos, exp_q.size());
    end
    total++;
    if (sr_cnt !== exp_ready) begin
      bad++;
      $display("FAIL %s s_ready_count: got %0d want %0d", name, sr_cnt, exp_ready);
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++;
      $display("FAIL %s err_count: got %0d want %0d", name, err_cnt, exp_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; sop_sel = 2'd0;
    load_payload('{}, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    total++;
    if ({tx_en, tx_bit, tx_flush, s_ready, busy, done, err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000",
               {tx_en, tx_bit, tx_flush, s_ready, busy, done, err});
    end
    rst = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_sop();
    rdy_period = 200;
    load_payload('{8'h41, 8'h10}, 1'b1);
    build_expected(S1, S1, S1, S2);
    @(negedge clock);
    run_frame(2'd0, 1'b0, "sop");
    total++;
    if (exp_q.size() + 1 !== 150) begin
      bad++;
      $display("FAIL sop_expected_len: got %0d want 150", exp_q.size() + 1);
    end
    verify_stream("sop", 2, 0);
    repeat (20) @(negedge clock);
    total++;
    if (done_cnt !== 1) begin
      bad++;
      $display("FAIL sop_done_count: got %0d want 1", done_cnt);
    end
    rdy_period = 4;
  endtask

  task automatic test_sop_prime_crc();
    logic [31:0] got;
    int base;
    logic [4:0] s;
    load_payload('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39}, 1'b1);
    build_expected(S1, S1, S3, S3);
    @(negedge clock);
    run_frame(2'd1, 1'b0, "sop1");
    verify_stream("sop1", 9, 0);
    base = PB + 20 + 90;
    got  = 32'h0;
    for (int n = 0; n < 8; n++) begin
      for (int b = 0; b < 5; b++)
        s[b] = (base + 5*n + b < cap_bit.size()) ? cap_bit[base + 5*n + b] : 1'bx;
      got[4*n +: 4] = dec5(s);
    end
    total++;
    if (got !== 32'hCBF43926) begin
      bad++;
      $display("FAIL crc_check_value: got %h want cbf43926", got);
    end
  endtask

  task automatic test_sop_sel();
    load_payload('{8'hA5}, 1'b1);
    build_expected(S1, S3, S1, S3);
    @(negedge clock);
    run_frame(2'd2, 1'b0, "sop2");
    verify_stream("sop2", 1, 0);
    load_payload('{8'hA5}, 1'b1);
    build_expected(S1, S1, S1, S2);
    @(negedge clock);
    run_frame(2'd3, 1'b0, "sop3");
    verify_stream("sop3", 1, 0);
  endtask

  task automatic test_underrun();
    load_payload('{8'h41}, 1'b0);
    build_expected(S1, S1, S1, S2);
    @(negedge clock);
    run_frame(2'd0, 1'b0, "underrun");
    total++;
    if (cap_bit.size() !== 100) begin
      bad++;
      $display("FAIL underrun_len: got %0d want 100", cap_bit.size());
    end
    verify_stream("underrun", 1, 1);
  endtask

  task automatic test_reset_mid();
    bit reached;
    load_payload('{8'h12, 8'h34}, 1'b1);
    @(negedge clock);
    cap_bit.delete(); cap_fl.delete();
    sop_sel = 2'd0;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (cap_bit.size() >= 70) begin reached = 1'b1; break; end
    end
    total++;
    if (!reached) begin
      bad++;
      $display("FAIL rst_mid_reach: only %0d bit periods", cap_bit.size());
    end
    rst = 1'b1;
    @(posedge clock); #1;
    total++;
    if ({tx_en, busy, tx_bit, tx_flush, s_ready, done, err} !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got %b want 0000000",
               {tx_en, busy, tx_bit, tx_flush, s_ready, done, err});
    end
    rst = 1'b0;
    load_payload('{8'h12, 8'h34}, 1'b1);
    build_expected(S1, S1, S1, S2);
    repeat (3) @(negedge clock);
    run_frame(2'd0, 1'b0, "after_rst");
    verify_stream("after_rst", 2, 0);
  endtask

  task automatic test_back_to_back();
    int act;
    load_payload('{8'hC3, 8'h5A}, 1'b1);
    build_expected(S1, S1, S3, S3);
    @(negedge clock);
    run_frame(2'd1, 1'b1, "poke");
    verify_stream("poke", 2, 0);
    load_payload('{8'h7E}, 1'b1);
    build_expected(S1, S1, S1, S2);
    run_frame(2'd0, 1'b0, "b2b");
    verify_stream("b2b", 1, 0);
    act = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (tx_en || busy || tx_bit || tx_flush || s_ready || done || err) act++;
    end
    total++;
    if (act !== 0) begin
      bad++;
      $display("FAIL idle_bit_rdy: %0d active cycles want 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_sop();
    test_sop_prime_crc();
    test_sop_sel();
    test_underrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pd_tx_framer.md
# pd_tx_framer

USB-PD transmit framer sitting directly upstream of the BMC encoder. Takes a message as a byte stream and serialises preamble, SOP ordered set, 4b5b-coded payload, CRC32 and EOP one bit per encoder bit-ready pulse. Also drives the encoder's enable and flush inputs, owning the whole TX burst from start to line release.

## Interface
- `PREAMBLE_BITS`, 64, number of alternating preamble bits (even, ≥2)
- `clock` in 1: system clock
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin frame; honoured only in IDLE
- `sop_sel` in 2: 0 = SOP, 1 = SOP', 2 = SOP'', 3 = SOP (treated as 0); sampled with `start`
- `s_data` in 8: payload byte
- `s_valid` in 1: `s_data` valid
- `s_last` in 1: current byte is the final payload byte
- `s_ready` out 1: byte accepted this cycle when `s_valid & s_ready`
- `bit_rdy` in 1: one-cycle pulse from encoder, end of current bit cell
- `tx_en` out 1: encoder enable
- `tx_bit` out 1: encoder data bit
- `tx_flush` out 1: encoder flush
- `busy` out 1: high from `start` acceptance until `done`
- `done` out 1: one-cycle pulse, frame complete
- `err` out 1: one-cycle pulse, payload underrun

## Operation
- States: IDLE → PREAMBLE → SOP → DATA → CRC → EOP → FLUSH → IDLE. Underrun: DATA → EOP.
- PREAMBLE: `PREAMBLE_BITS` bits, 0,1,0,1…, first bit 0.
- 5-bit symbols transmitted bit0 first; values written bit4..bit0. Data: 0=11110 1=01001 2=10100 3=10101 4=01010 5=01011 6=01110 7=01111 8=10010 9=10011 A=10110 B=10111 C=11010 D=11011 E=11100 F=11101. K-codes: Sync-1=11000, Sync-2=10001, Sync-3=00110, EOP=01101.
- SOP = S1,S1,S1,S2; SOP' = S1,S1,S3,S3; SOP'' = S1,S3,S1,S3.
- DATA: each byte low nibble symbol then high nibble symbol.
- CRC: CRC-32 reflected (poly 0xEDB88320, right-shift), init 0xFFFFFFFF, updated over payload bits LSB first; transmitted value = ~crc, as 4 bytes LSB byte first, each 4b5b-coded low nibble first (8 symbols). Check: payload "123456789" → transmitted 0xCBF43926.
- Byte fetch: `s_ready` = `s_valid` & fetch, where fetch is true in the cycle of the `bit_rdy` ending the last SOP bit or the last bit of a high-nibble symbol, unless the previous byte had `s_last`. Byte latched with its `s_last`; CRC updated within the byte's 10 bit periods.
- Underrun: fetch with `s_valid`=0 → `err` pulse, CRC skipped, EOP sent next, then FLUSH, `done`.
- After the byte with `s_last` completes → CRC → EOP.
- FLUSH: `tx_flush`=1, `tx_en`=1 for one bit period; on its `bit_rdy`, `tx_en`,`tx_flush` drop, `done` pulses, IDLE.
- `start` while `busy`: ignored. `bit_rdy` in IDLE: ignored.

## Timing
- Reset values: `tx_en`=0, `tx_bit`=0, `tx_flush`=0, `s_ready`=0, `busy`=0, `done`=0, `err`=0; state IDLE, CRC=0xFFFFFFFF.
- `rst` mid-frame: all outputs at reset values on the next edge; partially accepted message discarded.
- `start` at edge k → cycle k+1: `busy`=1, `tx_en`=1, `tx_bit`=first preamble bit.
- `tx_bit` registered; changes only on the cycle after a `bit_rdy`; stable for the whole bit cell.
- Bit periods per frame, N payload bytes: `PREAMBLE_BITS`+20+10N+40+5+1 (flush). Default, N=2: 150.
- `done` coincides with the cycle `tx_en` falls; `busy` falls same cycle. New `start` accepted the following cycle.

## Test plan
- SOP, payload {0x41,0x10}, `s_last` on 2nd, bit_rdy every 200 clocks → 150 bit periods; bit stream = 64 alternating, 11000×3/10001 (bit0 first), symbols 1,4,0,1, 8 CRC symbols of ~CRC, 01101, flush; one `done`; `s_ready` pulsed exactly twice.
- Payload "123456789", `sop_sel`=1 → SOP' ordered set S1,S1,S3,S3; CRC symbols decode to 0xCBF43926 LSB first.
- `sop_sel`=2 and 3 → S1,S3,S1,S3 and S1,S1,S1,S2 respectively.
- `s_valid` low at second fetch → `err` one pulse, EOP immediately after byte 1, no CRC symbols, `done`; total 64+20+10+5+1=100 bit periods.
- `rst` asserted at bit period 70 → next cycle `tx_en`=0, `busy`=0; subsequent `start` produces clean frame from preamble bit 0.
- `start` repeated during frame and `bit_rdy` pulses in IDLE → no effect on stream, counts, or outputs.
